// File: rtl/reverse_bits_arbiter_if.sv
// rtl/reverse_bits_arbiter_if.sv - requester/consumer handshake bundle for reverse_bits_arbiter
// Grant counters exist only when REVERSE_ARB_STATS_EN is defined.
interface reverse_bits_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int STAT_W = 16
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             q_valid;
    logic [WIDTH-1:0] q;
    logic             q_ready;
    logic             w_valid;
    logic [WIDTH-1:0] w;
    logic             w_ready;
`ifdef REVERSE_ARB_STATS_EN
    logic [STAT_W-1:0] a_grants;
    logic [STAT_W-1:0] b_grants;
`endif

    modport master (
        output a_valid, a_data, b_valid, b_data, q_ready, w_ready,
        input  a_ready, b_ready, q_valid, q, w_valid, w
`ifdef REVERSE_ARB_STATS_EN
        , input a_grants, b_grants
`endif
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, q_ready, w_ready,
        output a_ready, b_ready, q_valid, q, w_valid, w
`ifdef REVERSE_ARB_STATS_EN
        , output a_grants, b_grants
`endif
    );
endinterface

// File: rtl/reverse_bits_arbiter.sv
// rtl/reverse_bits_arbiter.sv - round-robin shared bit-reversal unit for two requesters
// Optional saturating grant counters enabled by REVERSE_ARB_STATS_EN.
module reverse_bits_arbiter #(
    parameter int WIDTH  = 8,
    parameter int STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reverse_bits_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             q_valid_q, q_valid_d;
    logic             w_valid_q, w_valid_d;
    logic             a_ready, b_ready;
    logic [WIDTH-1:0] reversed;

    always_comb begin
        reversed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = operand_q[WIDTH-1-i];
        end
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        q_d       = q_q;
        w_d       = w_q;
        owner_d   = owner_q;
        last_d    = last_q;
        q_valid_d = q_valid_q;
        w_valid_d = w_valid_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                a_ready = rst_n && bus.a_valid && (!bus.b_valid || last_q == OWN_B);
                b_ready = rst_n && bus.b_valid && (!bus.a_valid || last_q == OWN_A);
                if (a_ready) begin
                    operand_d = bus.a_data;
                    owner_d   = OWN_A;
                    last_d    = OWN_A;
                    state_d   = CALC;
                end else if (b_ready) begin
                    operand_d = bus.b_data;
                    owner_d   = OWN_B;
                    last_d    = OWN_B;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (owner_q == OWN_A) begin
                    q_d       = reversed;
                    q_valid_d = 1'b1;
                end else begin
                    w_d       = reversed;
                    w_valid_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                if (owner_q == OWN_A && bus.q_ready) begin
                    q_valid_d = 1'b0;
                    state_d   = IDLE;
                end else if (owner_q == OWN_B && bus.w_ready) begin
                    w_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            operand_q <= '0;
            q_q       <= '0;
            w_q       <= '0;
            owner_q   <= OWN_A;
            last_q    <= OWN_B;
            q_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            q_q       <= q_d;
            w_q       <= w_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            q_valid_q <= q_valid_d;
            w_valid_q <= w_valid_d;
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.q_valid = q_valid_q;
    assign bus.q       = q_q;
    assign bus.w_valid = w_valid_q;
    assign bus.w       = w_q;

`ifdef REVERSE_ARB_STATS_EN
    logic [STAT_W-1:0] a_cnt_q, a_cnt_d;
    logic [STAT_W-1:0] b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_ready && a_cnt_q != {STAT_W{1'b1}}) a_cnt_d = a_cnt_q + 1'b1;
        if (b_ready && b_cnt_q != {STAT_W{1'b1}}) b_cnt_d = b_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign bus.a_grants = a_cnt_q;
    assign bus.b_grants = b_cnt_q;
`endif
endmodule

// File: tb/tb_reverse_bits_arbiter.sv
// tb/tb_reverse_bits_arbiter.sv - scoreboard bench for reverse_bits_arbiter
module tb_reverse_bits_arbiter;
    localparam int WIDTH  = 8;
    localparam int STAT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reverse_bits_arbiter_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();
    reverse_bits_arbiter #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc     = 0;
    int rst_cnt = 0;
    bit rand_ready = 0;

    // reference model state
    bit               busy  = 0;
    bit               owner = 0;
    bit               last  = 1;
    int               acc_cyc = 0;
    logic [WIDTH-1:0] exp_res;
    logic [WIDTH-1:0] model_q = '0;
    logic [WIDTH-1:0] model_w = '0;
    logic [WIDTH-1:0] exp_a[$];
    logic [WIDTH-1:0] exp_b[$];
    int               ga = 0, gb = 0;
    int               log_cyc[$];
    bit               log_who[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        int v = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i]) v += (1 << (WIDTH - 1 - i));
        return WIDTH'(v);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rst_cnt++;
        else rst_cnt = 0;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.q_ready = 1'($urandom_range(0, 1));
            bus.w_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        bit win;
        logic [WIDTH-1:0] got;
        if (!rst_n) begin
            chk("rst_a_ready", bus.a_ready, 0);
            chk("rst_b_ready", bus.b_ready, 0);
            if (rst_cnt > 0) begin
                chk("rst_q_valid", bus.q_valid, 0);
                chk("rst_w_valid", bus.w_valid, 0);
                chk("rst_q", bus.q, 0);
                chk("rst_w", bus.w, 0);
`ifdef REVERSE_ARB_STATS_EN
                chk("rst_a_grants", bus.a_grants, 0);
                chk("rst_b_grants", bus.b_grants, 0);
`endif
            end
            busy = 0; last = 1; model_q = '0; model_w = '0;
            exp_a.delete(); exp_b.delete(); ga = 0; gb = 0;
        end else begin
            chk("ready_exclusive", bus.a_ready & bus.b_ready, 0);
`ifdef REVERSE_ARB_STATS_EN
            chk("a_grants", bus.a_grants, ga);
            chk("b_grants", bus.b_grants, gb);
`endif
            if (busy) begin
                chk("stall_a_ready", bus.a_ready, 0);
                chk("stall_b_ready", bus.b_ready, 0);
                if (cyc == acc_cyc + 1) begin
                    chk("calc_no_valid", bus.q_valid | bus.w_valid, 0);
                end else begin
                    if (cyc == acc_cyc + 2) begin
                        if (owner == 0) model_q = exp_res;
                        else model_w = exp_res;
                    end
                    chk(owner ? "w_valid_held" : "q_valid_held", owner ? bus.w_valid : bus.q_valid, 1);
                    chk(owner ? "q_valid_idle" : "w_valid_idle", owner ? bus.q_valid : bus.w_valid, 0);
                    if (owner == 0 && bus.q_valid && bus.q_ready) begin
                        got = (exp_a.size() > 0) ? exp_a.pop_front() : 'x;
                        chk("q_result", bus.q, got);
                        busy = 0;
                    end else if (owner == 1 && bus.w_valid && bus.w_ready) begin
                        got = (exp_b.size() > 0) ? exp_b.pop_front() : 'x;
                        chk("w_result", bus.w, got);
                        busy = 0;
                    end
                end
            end else begin
                chk("idle_q_valid", bus.q_valid, 0);
                chk("idle_w_valid", bus.w_valid, 0);
                if (bus.a_valid || bus.b_valid) begin
                    win = (bus.a_valid && bus.b_valid) ? !last : bus.b_valid;
                    chk("a_ready_grant", bus.a_ready, win == 0);
                    chk("b_ready_grant", bus.b_ready, win == 1);
                    busy = 1; owner = win; last = win; acc_cyc = cyc;
                    exp_res = rev(win ? bus.b_data : bus.a_data);
                    if (win) begin exp_b.push_back(exp_res); gb++; end
                    else begin exp_a.push_back(exp_res); ga++; end
                    log_cyc.push_back(cyc);
                    log_who.push_back(win);
                end else begin
                    chk("no_req_ready", bus.a_ready | bus.b_ready, 0);
                end
            end
            chk("q_retained", bus.q, model_q);
            chk("w_retained", bus.w, model_w);
        end
    end

    task automatic send_a(input logic [WIDTH-1:0] d);
        int t = 0;
        bus.a_valid = 1'b1;
        bus.a_data  = d;
        do begin @(negedge clk); t++; end while (!bus.a_ready && t < 300);
        if (t >= 300) chk("send_a_timeout", 0, 1);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [WIDTH-1:0] d);
        int t = 0;
        bus.b_valid = 1'b1;
        bus.b_data  = d;
        do begin @(negedge clk); t++; end while (!bus.b_ready && t < 300);
        if (t >= 300) chk("send_b_timeout", 0, 1);
        @(posedge clk); #1;
        bus.b_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || bus.q_valid || bus.w_valid) && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s, k, t;
        logic [WIDTH-1:0] da, db;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.a_data = 8'h5A; bus.b_data = 8'hA5;
        bus.q_ready = 1'b0; bus.w_ready = 1'b0;

        // reset with both requesters valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_a_ready", bus.a_ready, 0);
        chk("t1_b_ready", bus.b_ready, 0);
        @(posedge clk); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        rst_n = 1'b1;
        bus.q_ready = 1'b1; bus.w_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // single request from A
        send_a(8'b0000_0001);
        drain();
        chk("t2_q", bus.q, 8'b1000_0000);
        chk("t2_w", bus.w, 8'h00);

        // tie right after reset
        do_reset();
        s = log_who.size();
        fork
            send_a(8'h0F);
            send_b(8'hC3);
        join
        drain();
        chk("t3_first_is_a", log_who[s], 0);
        chk("t3_second_is_b", log_who[s+1], 1);
        chk("t3_q", bus.q, 8'hF0);
        chk("t3_w", bus.w, 8'hC3);

        // continuous contention, 12 operands
        s = log_who.size();
        fork
            for (int i = 0; i < 6; i++) send_a(8'($urandom));
            for (int i = 0; i < 6; i++) send_b(8'($urandom));
        join
        drain();
        for (int i = 0; i < 12; i++) begin
            chk("t4_alternate", log_who[s+i], i % 2);
            if (i > 0) chk("t4_spacing", log_cyc[s+i] - log_cyc[s+i-1], 3);
        end

        // backpressure on A's result with B waiting
        bus.q_ready = 1'b0;
        da = 8'($urandom); db = 8'($urandom);
        fork
            send_a(da);
            send_b(db);
        join_none
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.q_valid && t < 20);
        chk("t5_q_valid_seen", bus.q_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_q_valid_stable", bus.q_valid, 1);
            chk("t5_q_stable", bus.q, rev(da));
            chk("t5_b_ready_low", bus.b_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.q_ready = 1'b1;
        @(negedge clk);
        k = cyc;
        wait fork;
        chk("t5_b_next_who", log_who[log_who.size()-1], 1);
        chk("t5_b_next_cyc", log_cyc[log_cyc.size()-1], k + 1);
        drain();

        // reset while operand is in CALC
        send_a(8'h3C);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_q_valid", bus.q_valid, 0);
        end
        chk("t6_q_cleared", bus.q, 0);
`ifdef REVERSE_ARB_STATS_EN
        chk("t6_a_grants", bus.a_grants, 0);
        chk("t6_b_grants", bus.b_grants, 0);
`endif
        @(posedge clk); #1;

        // randomized traffic with random consumer backpressure
        rand_ready = 1;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                send_a(8'($urandom));
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                send_b(8'($urandom));
            end
        join
        rand_ready = 0;
        @(posedge clk); #2;
        bus.q_ready = 1'b1; bus.w_ready = 1'b1;
        drain();
        chk("final_a_queue_empty", exp_a.size(), 0);
        chk("final_b_queue_empty", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/reverse_bits_arbiter.md
Name: reverse_bits_arbiter

Overview:
- Shares one bit-reversal datapath between two requesters, A and B, using round-robin arbitration.
- Each requester has its own valid/ready input channel and its own valid/ready result channel.
- Sits between the stimulus and producer logic and the reverse-bits datapath. It sequences one operand at a time through capture, compute and result-hold phases.

Parameters:
- WIDTH, 8, operand and result width in bits; minimum 2.
- STAT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  clock; all logic updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- a_valid  in  1  requester A has an operand.
- a_data  in  WIDTH  requester A operand.
- a_ready  out  1  arbiter accepts A this cycle.
- b_valid  in  1  requester B has an operand.
- b_data  in  WIDTH  requester B operand.
- b_ready  out  1  arbiter accepts B this cycle.
- q_valid  out  1  result for A is available.
- q  out  WIDTH  reversed A operand.
- q_ready  in  1  A's consumer takes the result.
- w_valid  out  1  result for B is available.
- w  out  WIDTH  reversed B operand.
- w_ready  in  1  B's consumer takes the result.
- a_grants  out  STAT_W  A grant count; present only when the optional feature is enabled.
- b_grants  out  STAT_W  B grant count; present only when the optional feature is enabled.

Behaviour:
- Reset:
  - Reset is synchronous and active-low. When rst_n=0 at a clk edge, the block goes to state IDLE.
  - Reset values: q=0, w=0, q_valid=0, w_valid=0, operand register=0, owner=A, last_grant=B (so A wins the first tie), grant counters=0.
  - While rst_n=0, a_ready=0 and b_ready=0.
  - Reset mid-operation, in any state, drops the pending operand and any un-consumed result. Nothing is emitted afterwards for that operand.
- Handshake rules:
  - A transfer occurs on a cycle where valid=1 and ready=1 at the clk edge.
  - Requesters hold valid and data stable until accepted. The arbiter never asserts a_ready and b_ready in the same cycle.
- State machine (IDLE, CALC, DONE):
  - IDLE:
    - a_ready = a_valid AND (NOT b_valid OR last_grant==B).
    - b_ready = b_valid AND (NOT a_valid OR last_grant==A).
    - These are combinational from the valids and last_grant.
    - On acceptance: capture the data into the operand register, set owner and last_grant to the winner, go to CALC.
    - With no valid asserted, stay in IDLE.
  - CALC:
    - Both readies are 0.
    - Result register <= bit-reverse of the operand (result[i] = operand[WIDTH-1-i]).
    - Go to DONE.
  - DONE:
    - Drive the result to q with q_valid=1 if owner=A, or to w with w_valid=1 if owner=B.
    - Hold until the matching ready=1, then clear that valid and go to IDLE.
    - The other requester stalls for the whole period.
- Latency and throughput:
  - Accept at edge N; CALC spans the next cycle. q or w and its valid are driven from edge N+2 onward.
  - The result can be consumed at edge N+2 at the earliest. The next operand can be accepted at edge N+3 at the earliest, so peak throughput is one operand per 3 cycles.
- Output retention: q and w each keep their last result after consumption. Each changes only when its own owner's result is loaded.
- Fairness: with both requesters continuously valid, grants strictly alternate A, B, A, B...
- A consumer may hold ready=1 with nothing pending; this has no effect.

Optional Feature:
- Macro: REVERSE_ARB_STATS_EN.
- Defined:
  - a_grants and b_grants are present.
  - Each counter increments by 1 on its requester's accept handshake.
  - Counters saturate at 2^STAT_W-1 (no wrap) and clear on reset.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, q_valid=w_valid=0, q=w=8'h00.
2. Single request: A sends 8'b0000_0001 accepted at edge N, with q_ready=1 -> q=8'b1000_0000 and q_valid=1 at edge N+2; w_valid stays 0; w unchanged.
3. Tie after reset: A=8'h0F and B=8'hC3 asserted together, both consumers ready -> A accepted first, q=8'hF0; then B accepted, w=8'hC3. Grants are A then B.
4. Continuous contention: both valid for 12 operands -> grants alternate A, B, A, B...; each accept is spaced 3 cycles apart; every result equals the bit-reversed input.
5. Backpressure: q_ready=0 for 5 cycles after the A result appears -> q_valid and q stay stable and b_ready=0 throughout. After q_ready rises, B is accepted on the following cycle.
6. Reset mid-operation: rst_n=0 during CALC -> state returns to IDLE and no q_valid is produced for that operand. With REVERSE_ARB_STATS_EN defined, the counters read 0.
